// File: rtl/univ_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_pkg
//   Shared definitions for the universal shift/count register.
//   - mode_e      : 3-bit operation select encoding
//   - WIDTH_MIN/MAX : legal register width bounds
//   - is_legal_width() : helper used by the top-level elaboration check
// ---------------------------------------------------------------------------
package univ_shift_reg_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CNTUP = 3'b110,
        MODE_CNTDN = 3'b111
    } mode_e;

    function automatic bit is_legal_width(int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   WIDTH-bit register with hold / load / shift / rotate / count modes and a
//   one-cycle carry pulse whenever a count wraps.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   re        in   synchronous active-high reset (highest priority)
//   en        in   operation enable; 0 holds q regardless of mode
//   mode      in   [2:0] operation select (see univ_shift_reg_pkg::mode_e)
//   d         in   [WIDTH-1:0] parallel load data
//   ser_in_r  in   bit entering the LSB on shift left
//   ser_in_l  in   bit entering the MSB on shift right
//   q         out  [WIDTH-1:0] register contents
//   ser_out_l out  q[WIDTH-1]
//   ser_out_r out  q[0]
//   carry     out  registered pulse, high the cycle after a count wrap
//   zero      out  high when q == 0
// ---------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             re,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             carry,
    output logic             zero
);

    generate
        if (!is_legal_width(WIDTH)) begin : g_bad_width
            $error("univ_shift_reg: WIDTH out of range 2..32");
        end
    endgenerate

    // Reset value is truncated to the register width.
    localparam logic [31:0]      RST_FULL = RESET_VALUE;
    localparam logic [WIDTH-1:0] RST_Q    = RST_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZEROS    = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_nxt;
    logic             carry_nxt;

    // Next-state mux. Serial inputs are only referenced inside their own
    // shift branch, so an unknown serial input cannot leak into other modes.
    always_comb begin
        q_nxt     = q;
        carry_nxt = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD:  q_nxt = q;
                MODE_LOAD:  q_nxt = d;
                MODE_SHL:   q_nxt = {q[WIDTH-2:0], ser_in_r};
                MODE_SHR:   q_nxt = {ser_in_l, q[WIDTH-1:1]};
                MODE_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
                MODE_CNTUP: begin
                    q_nxt     = q + ONE;
                    carry_nxt = (q == ALL_ONES);
                end
                MODE_CNTDN: begin
                    q_nxt     = q - ONE;
                    carry_nxt = (q == ZEROS);
                end
                default:    q_nxt = q;
            endcase
        end
    end

    // carry is recomputed every cycle, so a pulse can never stretch; two
    // back-to-back wraps simply produce two back-to-back pulses.
    always_ff @(posedge clk) begin
        if (re) begin
            q     <= RST_Q;
            carry <= 1'b0;
        end else begin
            q     <= q_nxt;
            carry <= carry_nxt;
        end
    end

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];
    assign zero      = (q == ZEROS);

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit synchronous-reset flip-flop.
- A WIDTH-bit register with eight operating modes: hold, parallel load, logical shift left/right with serial inputs, rotate left/right, and count up/down.
- Carry/borrow pulse on count wrap.
- Used as the general-purpose storage/shift/count element in lab datapaths, e.g. LED chasers, serial links and tick counters.

Parameters:
- WIDTH, 8: register width in bits; legal range 2..32.
- RESET_VALUE, 0: value loaded into q on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- re  input  1  reset; synchronous, active-high.
- en  input  1  operation enable; 0 = hold regardless of mode.
- mode  input  3  operation select; encoding under Behaviour.
- d  input  WIDTH  parallel load data.
- ser_in_r  input  1  bit shifted into LSB on shift left.
- ser_in_l  input  1  bit shifted into MSB on shift right.
- q  output  WIDTH  register contents.
- ser_out_l  output  1  combinational copy of q[WIDTH-1].
- ser_out_r  output  1  combinational copy of q[0].
- carry  output  1  registered one-cycle pulse on count wrap.
- zero  output  1  combinational; 1 when q == 0.

Behaviour:
- Reset, priority over everything:
  - re=1 at a rising edge sets q <= RESET_VALUE and carry <= 0.
  - Reset mid-operation aborts the operation; the next edge with re=0 resumes normal operation.
- en=0 and re=0: q holds; carry <= 0.
- en=1 and re=0: next q selected by mode, with update latency of 1 clock:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], ser_in_r}.
  - 011 SHR: q <= {ser_in_l, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 CNTUP: q <= q + 1, modulo 2^WIDTH.
  - 111 CNTDN: q <= q - 1, modulo 2^WIDTH.
- carry:
  - Set to 1 for exactly one cycle after CNTUP with q == all-ones (wraps to 0).
  - Set to 1 for exactly one cycle after CNTDN with q == 0 (wraps to all-ones).
  - 0 after every other mode, after en=0, and after reset.
- Consecutive wraps, e.g. WIDTH-bit counting through 0 repeatedly, each produce their own pulse. The pulse is never stretched.
- Combinational outputs ser_out_l, ser_out_r and zero follow q with no extra latency.
- Mode changes take effect on the very next enabled edge; no internal state exists beyond q and carry.
- No X propagation from ser_in_* when they are not selected by mode.

Decomposition:
- Shared package univ_shift_reg_pkg holds:
  - the 3-bit mode constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CNTUP, MODE_CNTDN;
  - the legal WIDTH bounds.
- No sub-module required: one next-state mux plus one synchronous register process. The per-bit register is a WIDTH-wide generalisation of the existing flip-flop, so it needs no separate instance.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, re=1 for 1 edge -> q=A5, carry=0, zero=0; re=1 while en=1, mode=CNTUP -> q stays A5.
- Load/hold: load d=3C -> q=3C next cycle; then mode=LOAD with en=0 and d=FF -> q remains 3C, carry=0.
- Shift: q=81, SHL with ser_in_r=1 -> q=03, ser_out_l=0; SHR from 81 with ser_in_l=0 -> q=40, ser_out_r=0.
- Rotate: q=81, ROL -> 03, ROR -> C0; 8 consecutive ROL from any value -> original value restored.
- Count wrap: load FE, CNTUP 2 edges -> q=FF then 00, carry=1 only in the cycle q=00, zero=1; CNTDN from 00 -> q=FF, carry=1 one cycle, then 0 on the next CNTDN.
- Reset mid-count: CNTUP from FF with re=1 on the wrap edge -> q=RESET_VALUE, carry=0 (no pulse).
